// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared counter type and divisor helpers for the multi-channel tick divider.
package clock_div_pkg;
  localparam int CNT_W = 26;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t clamp_div(input cnt_t v);
    return (v < cnt_t'(2)) ? cnt_t'(2) : v;
  endfunction
  function automatic cnt_t high_len(input cnt_t d);
    return d - (d >> 1);
  endfunction
endpackage

// File: rtl/clock_div_chan.sv
// clock_div_chan: one divider channel with glitch-free divisor reload, freeze and sync restart.
module clock_div_chan import clock_div_pkg::*; #(
  parameter cnt_t DIV_DEFAULT = cnt_t'(50000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  cnt_t div,
  input  logic sync,
  input  cnt_t phase,
  output logic sq,
  output logic tick
);
  cnt_t d, p, cnt, d_new, cnt_n;
  logic pf, wrap, apply, adv;
  always_comb begin
    wrap  = cnt == d - cnt_t'(1);
    adv   = sync | en;
    apply = pf & (sync | (en & wrap));
    d_new = apply ? p : d;
    cnt_n = sync ? ((phase < d_new) ? phase : '0) : wrap ? '0 : cnt + cnt_t'(1);
  end
  // a load in the same cycle as a reload stays pending: pf is set after the old p is consumed
  always_ff @(posedge clk)
    if (!rst_n) begin
      d    <= clamp_div(DIV_DEFAULT);
      p    <= clamp_div(DIV_DEFAULT);
      pf   <= 1'b0;
      cnt  <= clamp_div(DIV_DEFAULT) - cnt_t'(1);
      sq   <= 1'b0;
      tick <= 1'b0;
    end else begin
      p    <= load ? clamp_div(div) : p;
      pf   <= load | (pf & ~apply);
      d    <= d_new;
      cnt  <= adv ? cnt_n : cnt;
      sq   <= adv ? (cnt_n < high_len(d_new)) : sq;
      tick <= adv & (cnt_n == '0);
    end
endmodule

// File: rtl/clock_div_multi.sv
// clock_div_multi: NCH programmable square/tick enable generators; CLKDIV_PHASE_EN adds phaseI sync offsets.
module clock_div_multi import clock_div_pkg::*; #(
  parameter int   NCH         = 4,
  parameter cnt_t DIV_DEFAULT = cnt_t'(50000)
) (
  input  logic                clkI,
  input  logic                rstNI,
  input  logic [NCH-1:0]      enI,
  input  logic [NCH-1:0]      loadI,
  input  cnt_t [NCH-1:0]      divI,
  input  logic                syncI,
`ifdef CLKDIV_PHASE_EN
  input  cnt_t [NCH-1:0]      phaseI,
`endif
  output logic [NCH-1:0]      clkO,
  output logic [NCH-1:0]      tickO
);
  cnt_t [NCH-1:0] phase;
`ifdef CLKDIV_PHASE_EN
  assign phase = phaseI;
`else
  assign phase = '0;
`endif
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clock_div_chan #(.DIV_DEFAULT(DIV_DEFAULT)) u_chan (
      .clk  (clkI),
      .rst_n(rstNI),
      .en   (enI[g]),
      .load (loadI[g]),
      .div  (divI[g]),
      .sync (syncI),
      .phase(phase[g]),
      .sq   (clkO[g]),
      .tick (tickO[g])
    );
  end
endmodule
